mem593_ctrl: RTL and testbench
==============================

MEM593_CTRL -- requirements
Module: mem593_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, number of wait states between request acceptance and response (0..15).
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, log2 of implemented word count (1..14).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cs  input  1  chip select from memory interface.
REQ-006 SHALL have port read_req  input  1  read request.
REQ-007 SHALL have port write_req  input  1  write request.
REQ-008 SHALL have port addrout  input  14  word address.
REQ-009 SHALL have port datatomem  input  16  write data.
REQ-010 SHALL have port datafrommem  output  16  read data, valid while mem_resp=1.
REQ-011 SHALL have port mem_resp  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  asserted with mem_resp when access was illegal.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP, HOLD.
REQ-015 SHALL accept a request in IDLE when cs=1 and (read_req|write_req)=1; latch addrout, datatomem, read_req, write_req at that edge.
REQ-016 SHALL go IDLE->WAIT on acceptance when WAIT_CYCLES>0, loading a 4-bit counter with WAIT_CYCLES-1; IDLE->RESP directly when WAIT_CYCLES=0.
REQ-017 SHALL decrement counter in WAIT, moving to RESP on the edge where counter=0.
REQ-018 SHALL drive mem_resp=1 for exactly the RESP cycle; acceptance at edge k gives mem_resp high in cycle k+WAIT_CYCLES+1.
REQ-019 SHALL commit a legal write to storage on the edge leaving RESP; read-during-same-address is not possible (one transaction at a time).
REQ-020 SHALL register read data so datafrommem shows the addressed word during RESP and hold it until the next read's RESP.
REQ-021 SHALL classify as illegal: read_req=1 and write_req=1 together, or addrout >= 2**DEPTH_LOG2.
REQ-022 SHALL, for illegal access, still complete with mem_resp after WAIT_CYCLES, assert err=1 in RESP only, perform no write, and drive datafrommem=16'h0000.
REQ-023 SHALL move RESP->HOLD; stay in HOLD while cs=1 and (read_req|write_req)=1; HOLD->IDLE when either drops, so a held request is never re-executed.
REQ-024 SHALL ignore input changes in WAIT, RESP, HOLD (latched copies used).
REQ-025 SHALL drop cs mid-transaction without effect: transaction completes normally.

Reset
REQ-026 SHALL on reset_n=0 immediately force state=IDLE, counter=0, mem_resp=0, err=0, busy=0, datafrommem=16'h0000.
REQ-027 SHALL abort an in-flight transaction on reset with no storage write and no mem_resp.
REQ-028 SHALL NOT clear storage array on reset; contents undefined until written.

Structure
REQ-029 SHALL place mem_state_t enum and MEM_DATA_W=16, MEM_ADDR_W=14 constants in tinyalu_pkg.
REQ-030 SHALL use one sub-module, mem593_array (synchronous-write, registered-read word array, DEPTH_LOG2 parameter); FSM and counter stay in mem593_ctrl.

Verification
REQ-031 SHALL cover: write addr 14'h0010 data 16'hBEEF, then read 14'h0010 (WAIT_CYCLES=2) -> mem_resp 3 cycles after each acceptance, read returns 16'hBEEF, err=0.
REQ-032 SHALL cover: cs, read_req, write_req all 1 at addr 14'h0004 -> mem_resp with err=1, datafrommem=16'h0000, word 4 unchanged on read-back.
REQ-033 SHALL cover: write addr 14'h0400 with DEPTH_LOG2=10 -> err=1, no write; read 14'h03FF legal, err=0.
REQ-034 SHALL cover: request held high for 10 cycles after mem_resp -> exactly one mem_resp, busy=1 until request drops, then IDLE.
REQ-035 SHALL cover: reset_n pulsed low during WAIT of write 16'h1234 to 14'h0020 -> no mem_resp, busy=0 immediately, later read of 14'h0020 does not return 16'h1234 unless previously written.
REQ-036 SHALL cover: WAIT_CYCLES=0 back-to-back read/write -> mem_resp in cycle after acceptance, HOLD->IDLE->accept sequence correct.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// Shared types and constants for the mem593 word-memory controller slice.
package tinyalu_pkg;

  localparam int MEM_DATA_W = 16;
  localparam int MEM_ADDR_W = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } mem_state_t;

  // True when the word address falls inside the implemented 2**depth_log2 words.
  function automatic logic addr_in_range(input logic [MEM_ADDR_W-1:0] addr,
                                         input int depth_log2);
    return (addr >> depth_log2) == '0;
  endfunction

endpackage

// File: rtl/mem593_array.sv
// Word storage: synchronous write, registered read. Contents are never reset.
module mem593_array #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]     i_wr_data,
  input  logic                  i_rd_en,
  input  logic [DEPTH_LOG2-1:0] i_rd_addr,
  output logic [DATA_W-1:0]     o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mem593_ctrl.sv
// Single-transaction memory controller: accept, wait WAIT_CYCLES, pulse mem_resp,
// then hold until the requester releases so a held request is not replayed.
module mem593_ctrl
  import tinyalu_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2  = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cs,
  input  logic                  read_req,
  input  logic                  write_req,
  input  logic [MEM_ADDR_W-1:0] addrout,
  input  logic [MEM_DATA_W-1:0] datatomem,
  output logic [MEM_DATA_W-1:0] datafrommem,
  output logic                  mem_resp,
  output logic                  err,
  output logic                  busy,
  output mem_state_t            o_dbg_state
);

  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  mem_state_t            r_state, w_next;
  logic [3:0]            r_cnt, w_cnt_next;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic [MEM_DATA_W-1:0] r_wdata, r_hold;
  logic                  r_rd, r_wr, r_illegal;
  logic                  w_req, w_accept, w_illegal, w_we, w_rd_en;
  logic [MEM_DATA_W-1:0] w_rd_data;

  // Handshake: a request is taken in IDLE when cs & (read_req|write_req); the
  // requester sees mem_resp for one cycle and must drop the request to re-arm.
  assign w_req     = cs & (read_req | write_req);
  assign w_accept  = (r_state == IDLE) & w_req;
  assign w_illegal = (read_req & write_req) | ~addr_in_range(addrout, DEPTH_LOG2);

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: if (w_accept) begin
        if (WAIT_CYCLES == 0) w_next = RESP;
        else begin
          w_next     = WAIT;
          w_cnt_next = WAIT_LOAD;
        end
      end
      WAIT: if (r_cnt == 4'd0) w_next = RESP;
            else w_cnt_next = r_cnt - 4'd1;
      RESP: w_next = HOLD;
      HOLD: if (!w_req) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_illegal <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr    <= addrout[DEPTH_LOG2-1:0];
        r_wdata   <= datatomem;
        r_rd      <= read_req;
        r_wr      <= write_req;
        r_illegal <= w_illegal;
      end
      if (r_state == RESP && r_rd && !r_illegal) r_hold <= w_rd_data;
    end
  end

  // Storage is read at acceptance; nothing can write it before this RESP.
  assign w_rd_en = w_accept & read_req & ~w_illegal;
  assign w_we    = (r_state == RESP) & r_wr & ~r_illegal;

  mem593_array #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_W    (MEM_DATA_W)
  ) u_array (
    .clk      (clk),
    .i_we     (w_we),
    .i_wr_addr(r_addr),
    .i_wr_data(r_wdata),
    .i_rd_en  (w_rd_en),
    .i_rd_addr(addrout[DEPTH_LOG2-1:0]),
    .o_rd_data(w_rd_data)
  );

  assign mem_resp    = (r_state == RESP);
  assign err         = mem_resp & r_illegal;
  assign busy        = (r_state != IDLE);
  assign o_dbg_state = r_state;
  assign datafrommem = !mem_resp ? r_hold :
                       r_illegal ? '0 :
                       r_rd      ? w_rd_data : r_hold;

endmodule

// File: tb/tb_mem593_ctrl.sv
// Bench for mem593_ctrl: two instances (WAIT_CYCLES=2 and 0) share one stimulus
// stream and are each compared every cycle against a transaction-level model.
module tb_mem593_ctrl;
  import tinyalu_pkg::*;

  localparam int W0 = 2;
  localparam int W1 = 0;
  localparam int NWORDS = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0, read_req = 1'b0, write_req = 1'b0;
  logic [13:0] addrout = '0;
  logic [15:0] datatomem = '0;

  logic [15:0] dfm0, dfm1;
  logic        resp0, resp1, err0, err1, busy0, busy1;
  mem_state_t  st0, st1;

  always #5 clk = ~clk;

  mem593_ctrl #(.WAIT_CYCLES(W0), .DEPTH_LOG2(10)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .cs(cs), .read_req(read_req), .write_req(write_req),
    .addrout(addrout), .datatomem(datatomem), .datafrommem(dfm0), .mem_resp(resp0),
    .err(err0), .busy(busy0), .o_dbg_state(st0));

  mem593_ctrl #(.WAIT_CYCLES(W1), .DEPTH_LOG2(10)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .cs(cs), .read_req(read_req), .write_req(write_req),
    .addrout(addrout), .datatomem(datatomem), .datafrommem(dfm1), .mem_resp(resp1),
    .err(err1), .busy(busy1), .o_dbg_state(st1));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int          edge_n = 0;
  bit          pend[2], hld[2];
  int          resp_edge[2];
  logic        m_rd[2], m_wr[2], m_ill[2];
  logic [13:0] m_addr[2];
  logic [15:0] m_data[2];
  logic [15:0] m_hold[2];
  bit          m_hold_known[2];
  logic [15:0] m_mem[2][NWORDS];
  bit          m_known[2][NWORDS];

  function automatic int waits(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  always @(posedge clk) begin
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        pend[i] = 0; hld[i] = 0; m_hold[i] = '0; m_hold_known[i] = 1;
      end else if (hld[i]) begin
        if (!(cs && (read_req || write_req))) hld[i] = 0;
      end else if (pend[i]) begin
        if (edge_n == resp_edge[i] + 1) begin
          if (!m_ill[i] && m_wr[i]) begin
            m_mem[i][m_addr[i][9:0]] = m_data[i];
            m_known[i][m_addr[i][9:0]] = 1;
          end
          if (!m_ill[i] && m_rd[i]) begin
            m_hold[i] = m_mem[i][m_addr[i][9:0]];
            m_hold_known[i] = m_known[i][m_addr[i][9:0]];
          end
          pend[i] = 0; hld[i] = 1;
        end
      end else if (cs && (read_req || write_req)) begin
        pend[i] = 1;
        resp_edge[i] = edge_n + waits(i);
        m_rd[i] = read_req; m_wr[i] = write_req;
        m_addr[i] = addrout; m_data[i] = datatomem;
        m_ill[i] = (read_req && write_req) || (int'(addrout) >= NWORDS);
      end
    end
  end

  task automatic get_out(input int i, output logic r, output logic e, output logic b,
                         output logic [15:0] d, output mem_state_t s);
    r = (i == 0) ? resp0 : resp1;
    e = (i == 0) ? err0 : err1;
    b = (i == 0) ? busy0 : busy1;
    d = (i == 0) ? dfm0 : dfm1;
    s = (i == 0) ? st0 : st1;
  endtask

  // Compare process: every mid-cycle, both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic r, e, b, ex_r, ex_b, d_known;
      logic [15:0] d, ex_d;
      mem_state_t s;
      get_out(i, r, e, b, d, s);
      if (!reset_n) begin
        chk($sformatf("rst_resp%0d", i), r, 0);
        chk($sformatf("rst_err%0d", i), e, 0);
        chk($sformatf("rst_busy%0d", i), b, 0);
        chk($sformatf("rst_data%0d", i), d, 0);
        chk($sformatf("rst_state%0d", i), s, IDLE);
      end else begin
        ex_r = pend[i] && (edge_n == resp_edge[i]);
        ex_b = pend[i] || hld[i];
        ex_d = m_hold[i]; d_known = m_hold_known[i];
        if (ex_r && m_ill[i]) begin
          ex_d = '0; d_known = 1;
        end else if (ex_r && m_rd[i]) begin
          ex_d = m_mem[i][m_addr[i][9:0]]; d_known = m_known[i][m_addr[i][9:0]];
        end
        chk($sformatf("resp%0d", i), r, ex_r);
        chk($sformatf("err%0d", i), e, ex_r && m_ill[i]);
        chk($sformatf("busy%0d", i), b, ex_b);
        chk($sformatf("idle_state%0d", i), s == IDLE, !ex_b);
        if (d_known) chk($sformatf("data%0d", i), d, ex_d);
      end
    end
  end

  // ---------------- directed driver ----------------
  int          o_cnt[2], o_lat[2];
  logic [15:0] o_dat[2];
  logic        o_err[2], o_busy_held[2], o_busy_after[2];

  task automatic set_req(input logic c, input logic rd, input logic wr,
                         input logic [13:0] a, input logic [15:0] d);
    cs = c; read_req = rd; write_req = wr; addrout = a; datatomem = d;
  endtask

  // Hold the request for 'hold' cycles, then idle for 'gap' (>=1) cycles,
  // recording each instance's response count, latency, data and err.
  task automatic txn(input logic rd, input logic wr, input logic [13:0] a,
                     input logic [15:0] d, input int hold, input int gap);
    @(negedge clk); #1;
    set_req(1, rd, wr, a, d);
    for (int i = 0; i < 2; i++) begin
      o_cnt[i] = 0; o_lat[i] = -1; o_dat[i] = 'x; o_err[i] = 'x;
    end
    for (int j = 0; j < hold + gap; j++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic r, e, b;
        logic [15:0] dd;
        mem_state_t s;
        get_out(i, r, e, b, dd, s);
        if (r) begin
          o_cnt[i]++;
          if (o_lat[i] < 0) begin
            o_lat[i] = j + 1; o_dat[i] = dd; o_err[i] = e;
          end
        end
        if (j == hold - 1) o_busy_held[i] = b;
        if (j == hold) o_busy_after[i] = b;
      end
      #1;
      if (j == hold - 1) set_req(0, 0, 0, '0, '0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // write then read back
    txn(0, 1, 14'h0010, 16'hBEEF, 5, 2);
    chk("wr_lat0", o_lat[0], 3); chk("wr_lat1", o_lat[1], 1);
    chk("wr_err0", o_err[0], 0);
    txn(1, 0, 14'h0010, 16'h0000, 5, 2);
    chk("rd_lat0", o_lat[0], 3); chk("rd_lat1", o_lat[1], 1);
    chk("rd_beef0", o_dat[0], 16'hBEEF); chk("rd_beef1", o_dat[1], 16'hBEEF);
    chk("rd_err0", o_err[0], 0);

    // read+write together is illegal and must not write
    txn(0, 1, 14'h0004, 16'h1111, 5, 2);
    txn(1, 1, 14'h0004, 16'h2222, 5, 2);
    chk("both_err0", o_err[0], 1); chk("both_err1", o_err[1], 1);
    chk("both_data0", o_dat[0], 0); chk("both_lat0", o_lat[0], 3);
    txn(1, 0, 14'h0004, 16'h0000, 5, 2);
    chk("w4_kept0", o_dat[0], 16'h1111); chk("w4_kept1", o_dat[1], 16'h1111);

    // out-of-range write, no aliasing onto word 0; top legal word
    txn(0, 1, 14'h0000, 16'h0F0F, 5, 2);
    txn(0, 1, 14'h03FF, 16'hA5A5, 5, 2);
    txn(0, 1, 14'h0400, 16'hDEAD, 5, 2);
    chk("oor_err0", o_err[0], 1); chk("oor_err1", o_err[1], 1);
    txn(1, 0, 14'h03FF, 16'h0000, 5, 2);
    chk("top_err0", o_err[0], 0); chk("top_data0", o_dat[0], 16'hA5A5);
    txn(1, 0, 14'h0000, 16'h0000, 5, 2);
    chk("w0_kept0", o_dat[0], 16'h0F0F);

    // request held long after the response
    txn(0, 1, 14'h0030, 16'h7777, 14, 3);
    chk("hold_cnt0", o_cnt[0], 1); chk("hold_cnt1", o_cnt[1], 1);
    chk("hold_busy0", o_busy_held[0], 1); chk("hold_busy1", o_busy_held[1], 1);
    chk("hold_idle0", o_busy_after[0], 0); chk("hold_idle1", o_busy_after[1], 0);

    // reset during WAIT aborts the write
    txn(0, 1, 14'h0020, 16'h5555, 5, 2);
    @(negedge clk); #1 set_req(1, 0, 1, 14'h0020, 16'h1234);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("abort_busy0", busy0, 0); chk("abort_busy1", busy1, 0);
    chk("abort_resp1", resp1, 0);
    set_req(0, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    txn(1, 0, 14'h0020, 16'h0000, 5, 2);
    chk("abort_kept0", o_dat[0], 16'h5555); chk("abort_kept1", o_dat[1], 16'h5555);

    // back-to-back with one idle cycle between requests
    txn(1, 0, 14'h0010, 16'h0000, 2, 1);
    chk("b2b_rd_lat1", o_lat[1], 1); chk("b2b_rd1", o_dat[1], 16'hBEEF);
    txn(0, 1, 14'h0011, 16'hCAFE, 2, 1);
    chk("b2b_wr_lat1", o_lat[1], 1); chk("b2b_wr_cnt1", o_cnt[1], 1);
    txn(1, 0, 14'h0011, 16'h0000, 2, 4);
    chk("b2b_rd2_lat1", o_lat[1], 1); chk("b2b_rd2_1", o_dat[1], 16'hCAFE);

    // randomized traffic, checked by the compare process
    repeat (600) begin
      int k, r;
      logic [13:0] a;
      @(negedge clk); #1;
      if ($urandom_range(0, 199) == 0) begin
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1 reset_n = 1'b1;
      end
      r = $urandom_range(0, 9);
      if (r < 7)      a = 14'($urandom_range(0, 31));
      else if (r < 9) a = 14'($urandom_range(1000, 1023));
      else            a = 14'($urandom_range(1024, 16383));
      k = $urandom_range(0, 9);
      set_req($urandom_range(0, 3) != 0, (k == 0) || (k >= 1 && k <= 4),
              (k == 0) || (k >= 5 && k <= 8), a, 16'($urandom));
    end
    @(negedge clk); #1 set_req(0, 0, 0, '0, '0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("final_busy0", busy0, 0); chk("final_busy1", busy1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
